// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS serializer: control symbols and
// the bits-per-clock derivation used by every serializer configuration.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic int bpc(input int ddr);
    return (ddr != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/tmds_shift_lane.sv
// One serializer lane: parallel load at the symbol boundary, otherwise shifts
// BPC bits per clock toward the output end. bits[0] is always the earlier bit.
module tmds_shift_lane #(
  parameter int WIDTH     = 10,
  parameter int BPC       = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [BPC-1:0]   bits
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (LSB_FIRST != 0) begin
      sreg <= sreg >> BPC;
    end else begin
      sreg <= sreg << BPC;
    end
  end

  for (genvar b = 0; b < BPC; b++) begin : g_bit
    if (LSB_FIRST != 0) begin : g_lsb
      assign bits[b] = sreg[b];
    end else begin : g_msb
      assign bits[b] = sreg[WIDTH-1-b];
    end
  end

endmodule

// File: rtl/tmds_serializer_mc.sv
// Multi-lane lock-step serializer with a one-word holding register, idle-symbol
// insertion on starvation and a sticky, saturating underflow monitor.
module tmds_serializer_mc
  import tmds_pkg::*;
#(
  parameter int               CHANNELS  = 3,
  parameter int               WIDTH     = 10,
  parameter int               DDR       = 1,
  parameter int               LSB_FIRST = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD = TMDS_CTRL_00,
  parameter int               CNT_W     = 16
) (
  input  logic                             clk_5x,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*WIDTH-1:0]        in_data,
  output logic [CHANNELS*bpc(DDR)-1:0]     out_bits,
  output logic                             word_strobe,
  output logic                             underflow,
  output logic [CNT_W-1:0]                 underflow_cnt,
  input  logic                             underflow_clr
);

  localparam int BPC  = bpc(DDR);
  localparam int S    = WIDTH / BPC;
  localparam int PH_W = (S > 1) ? $clog2(S) : 1;

  if (((WIDTH % BPC) != 0) || (S < 2)) begin : g_bad_cfg
    $fatal(1, "tmds_serializer_mc: WIDTH must be a multiple of BPC with at least 2 cycles per symbol");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PH_W-1:0]           ph;
  logic                      boundary;
  logic                      accept;
  logic                      hold_valid;
  logic [CHANNELS*WIDTH-1:0] hold_data;
  logic                      armed;
  logic                      underflow_evt;

  assign boundary      = (ph == PH_W'(S-1));
  assign in_ready      = !hold_valid || boundary;
  assign accept        = in_valid && in_ready;
  assign underflow_evt = boundary && !hold_valid && armed;

  always_ff @(posedge clk_5x or posedge rst) begin
    if (rst) begin
      ph          <= PH_W'(S-1);
      hold_valid  <= 1'b0;
      armed       <= 1'b0;
      word_strobe <= 1'b0;
    end else begin
      ph          <= boundary ? '0 : ph + 1'b1;
      word_strobe <= boundary;
      if (accept) begin
        hold_valid <= 1'b1;
        armed      <= 1'b1;
      end else if (boundary) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Holding data needs no reset: it is only consumed while hold_valid is set.
  always_ff @(posedge clk_5x) begin
    if (accept) hold_data <= in_data;
  end

  always_ff @(posedge clk_5x or posedge rst) begin
    if (rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (underflow_clr) begin
      underflow     <= underflow_evt;
      underflow_cnt <= underflow_evt ? CNT_W'(1) : '0;
    end else if (underflow_evt) begin
      underflow     <= 1'b1;
      underflow_cnt <= sat_inc(underflow_cnt);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tmds_shift_lane #(
      .WIDTH    (WIDTH),
      .BPC      (BPC),
      .LSB_FIRST(LSB_FIRST)
    ) u_lane (
      .clk      (clk_5x),
      .rst      (rst),
      .load     (boundary),
      .load_data(hold_valid ? hold_data[c*WIDTH +: WIDTH] : IDLE_WORD),
      .bits     (out_bits[c*BPC +: BPC])
    );
  end

endmodule

// File: tb/tb_tmds_serializer_mc.sv
// Bench for tmds_serializer_mc: default DDR/LSB-first, MSB-first, small-counter
// and SDR instances driven from one scenario sequence with a symbol scoreboard.
module tb_tmds_serializer_mc;
  import tmds_pkg::*;

  localparam int W = 10;
  localparam int C = 3;
  localparam logic [29:0] IDLE3 = {3{TMDS_CTRL_00}};

  logic        clk_5x = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid_s = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [29:0] in_data = '0;
  logic [29:0] in_data_s = '0;

  logic        in_ready, in_ready_m, in_ready_t, in_ready_s;
  logic [5:0]  out_bits, out_m, out_t;
  logic [2:0]  out_s;
  logic        strobe, strobe_m, strobe_t, strobe_s;
  logic        uf, uf_m, uf_t, uf_s;
  logic [15:0] cnt, cnt_m, cnt_s;
  logic [1:0]  cnt_t;

  logic [29:0] exp_q[$];
  logic [29:0] got_q[$];
  logic [29:0] got_m_q[$];
  logic [29:0] exp_s_q[$];
  int          idle_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  tmds_serializer_mc dut (
    .clk_5x(clk_5x), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_bits(out_bits), .word_strobe(strobe),
    .underflow(uf), .underflow_cnt(cnt), .underflow_clr(underflow_clr));

  tmds_serializer_mc #(.LSB_FIRST(0)) dut_msb (
    .clk_5x(clk_5x), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .out_bits(out_m), .word_strobe(strobe_m),
    .underflow(uf_m), .underflow_cnt(cnt_m), .underflow_clr(underflow_clr));

  tmds_serializer_mc #(.CNT_W(2)) dut_sat (
    .clk_5x(clk_5x), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_data(in_data), .out_bits(out_t), .word_strobe(strobe_t),
    .underflow(uf_t), .underflow_cnt(cnt_t), .underflow_clr(underflow_clr));

  tmds_serializer_mc #(.DDR(0)) dut_sdr (
    .clk_5x(clk_5x), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_data(in_data_s), .out_bits(out_s), .word_strobe(strobe_s),
    .underflow(uf_s), .underflow_cnt(cnt_s), .underflow_clr(underflow_clr));

  always #5 clk_5x = ~clk_5x;

  // Symbol monitor: rebuilds each symbol of the DDR instances from the strobe onward.
  initial begin
    int mj;
    logic [29:0] acc, accm;
    mj = -1; acc = '0; accm = '0;
    forever begin
      @(negedge clk_5x);
      if (rst) begin
        mj = -1;
      end else begin
        if (strobe) mj = 0;
        if (mj >= 0) begin
          for (int c = 0; c < C; c++) begin
            acc[c*W + 2*mj +: 2]   = out_bits[c*2 +: 2];
            accm[c*W + 9 - 2*mj]   = out_m[c*2];
            accm[c*W + 8 - 2*mj]   = out_m[c*2+1];
          end
          if (mj == 4) begin
            if (acc == IDLE3) idle_cnt++;
            else got_q.push_back(acc);
            if (accm != IDLE3) got_m_q.push_back(accm);
            mj = -1;
          end else begin
            mj++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_5x);
  endtask

  task automatic wait_strobe();
    int t;
    t = 0;
    @(negedge clk_5x);
    while (!strobe && t < 50) begin @(negedge clk_5x); t++; end
    if (!strobe) begin n_checks++; n_fail++; $display("FAIL wait_strobe timeout"); end
  endtask

  task automatic send(input logic [29:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 50) begin @(negedge clk_5x); t++; end
    if (!in_ready) begin n_checks++; n_fail++; $display("FAIL send timeout"); end
    @(negedge clk_5x);
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_checks++; if ({in_ready, in_ready_m, in_ready_t, in_ready_s} !== 4'hF) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1111", {in_ready, in_ready_m, in_ready_t, in_ready_s}); end
    n_checks++; if ({out_bits, out_m, out_t, out_s} !== 21'd0) begin n_fail++; $display("FAIL reset_out_bits got=%h exp=0", {out_bits, out_m, out_t, out_s}); end
    n_checks++; if ({strobe, strobe_m, strobe_t, strobe_s, uf, uf_m, uf_t, uf_s} !== 8'd0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0", {strobe, strobe_m, strobe_t, strobe_s, uf, uf_m, uf_t, uf_s}); end
    n_checks++; if ({cnt, cnt_m, cnt_t, cnt_s} !== 50'd0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", {cnt, cnt_m, cnt_t, cnt_s}); end
    rst = 1'b0;
    cyc(1);
    n_checks++; if ({strobe, strobe_s} !== 2'b11) begin n_fail++; $display("FAIL first_strobe got=%b exp=11", {strobe, strobe_s}); end
    n_checks++; if (out_bits !== 6'b000000) begin n_fail++; $display("FAIL first_idle_bits0 got=%b exp=000000", out_bits); end
    n_checks++; if (out_s !== 3'b000) begin n_fail++; $display("FAIL first_idle_sdr got=%b exp=000", out_s); end
    cyc(1);
    n_checks++; if (out_bits !== 6'b010101) begin n_fail++; $display("FAIL first_idle_bits1 got=%b exp=010101", out_bits); end
    n_checks++; if ({uf, cnt} !== 17'd0) begin n_fail++; $display("FAIL unarmed_idle_uf got=%h exp=0", {uf, cnt}); end
  endtask

  task automatic test_stream();
    logic [29:0] w;
    logic [15:0] cnt0;
    w = {10'h155, 10'h000, 10'h3FF};
    send(w);
    cnt0 = cnt;
    for (int i = 0; i < 5; i++) send(w);
    in_valid = 1'b0;
    n_checks++; if (uf !== 1'b0 || cnt !== cnt0) begin n_fail++; $display("FAIL stream_no_underflow got=%b/%0d exp=0/%0d", uf, cnt, cnt0); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_bits !== 6'b010011) begin n_fail++; $display("FAIL stream_bits[%0d] got=%b exp=010011", i, out_bits); end
      n_checks++; if (strobe !== (i % 5 == 0)) begin n_fail++; $display("FAIL stream_strobe[%0d] got=%b exp=%b", i, strobe, (i % 5 == 0)); end
      cyc(1);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] w;
    for (int i = 0; i < 8; i++) begin
      w = {$urandom, $urandom} & 30'h3FFF_FFFF;
      if (w == IDLE3) w = w ^ 30'h1;
      send(w);
    end
    in_valid = 1'b0;
    cyc(15);
  endtask

  task automatic test_bit_order();
    int t;
    cyc(10);
    send(30'h0000_0003);
    in_valid = 1'b0;
    t = 0;
    while (!(strobe && out_bits[1:0] == 2'b11) && t < 40) begin cyc(1); t++; end
    n_checks++; if (t >= 40) begin n_fail++; $display("FAIL bit_order_wait got=timeout exp=strobe"); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_bits[1:0] !== ((i == 0) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL lsb_first[%0d] got=%b exp=%b", i, out_bits[1:0], (i == 0) ? 2'b11 : 2'b00); end
      n_checks++; if (out_m[1:0] !== ((i == 4) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL msb_first[%0d] got=%b exp=%b", i, out_m[1:0], (i == 4) ? 2'b11 : 2'b00); end
      cyc(1);
    end
    cyc(5);
  endtask

  task automatic test_underflow();
    int idle0;
    wait_strobe();
    cyc(4);
    in_valid = 1'b1; in_data = {10'h2AA, 10'h0F0, 10'h00F};
    cyc(1);
    in_valid = 1'b0; exp_q.push_back({10'h2AA, 10'h0F0, 10'h00F}); underflow_clr = 1'b1;
    cyc(1);
    underflow_clr = 1'b0;
    n_checks++; if ({uf, cnt, uf_t, cnt_t} !== 20'd0) begin n_fail++; $display("FAIL clr_before got=%h exp=0", {uf, cnt, uf_t, cnt_t}); end
    cyc(4);
    idle0 = idle_cnt;
    cyc(4);
    in_valid = 1'b1; in_data = {10'h111, 10'h222, 10'h333};
    cyc(1);
    in_valid = 1'b0; exp_q.push_back({10'h111, 10'h222, 10'h333});
    n_checks++; if (uf !== 1'b1 || cnt !== 16'd1) begin n_fail++; $display("FAIL underflow_set got=%b/%0d exp=1/1", uf, cnt); end
    n_checks++; if (uf_t !== 1'b1 || cnt_t !== 2'd1) begin n_fail++; $display("FAIL underflow_set_small got=%b/%0d exp=1/1", uf_t, cnt_t); end
    underflow_clr = 1'b1;
    cyc(1);
    underflow_clr = 1'b0;
    n_checks++; if (uf !== 1'b0 || cnt !== 16'd0) begin n_fail++; $display("FAIL underflow_clr got=%b/%0d exp=0/0", uf, cnt); end
    cyc(9);
    n_checks++; if (idle_cnt - idle0 !== 1) begin n_fail++; $display("FAIL idle_inserted got=%0d exp=1", idle_cnt - idle0); end
  endtask

  task automatic test_saturation();
    wait_strobe();
    underflow_clr = 1'b1;
    cyc(1);
    underflow_clr = 1'b0;
    n_checks++; if (cnt !== 16'd0 || cnt_t !== 2'd0) begin n_fail++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", cnt, cnt_t); end
    cyc(25);
    n_checks++; if (cnt_t !== 2'b11 || uf_t !== 1'b1) begin n_fail++; $display("FAIL saturate got=%b/%b exp=11/1", cnt_t, uf_t); end
    n_checks++; if (cnt !== 16'd5) begin n_fail++; $display("FAIL count5 got=%0d exp=5", cnt); end
    wait_strobe();
    cyc(4);
    underflow_clr = 1'b1;
    cyc(1);
    underflow_clr = 1'b0;
    n_checks++; if (cnt !== 16'd1 || uf !== 1'b1) begin n_fail++; $display("FAIL clr_and_uf got=%0d/%b exp=1/1", cnt, uf); end
    n_checks++; if (cnt_t !== 2'd1 || uf_t !== 1'b1) begin n_fail++; $display("FAIL clr_and_uf_small got=%0d/%b exp=1/1", cnt_t, uf_t); end
  endtask

  task automatic test_scoreboard();
    logic [29:0] e, g;
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_m_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sb_count_msb got=%0d exp=%0d", got_m_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL sb_symbol got=%h exp=%h", g, e); end
      end
      if (got_m_q.size() > 0) begin
        g = got_m_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL sb_symbol_msb got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_sdr_latency();
    int t;
    logic [29:0] w, g;
    w = {10'h333, 10'h0F0, 10'h2A5};
    t = 0;
    cyc(1);
    while (!strobe_s && t < 40) begin cyc(1); t++; end
    n_checks++; if (!strobe_s) begin n_fail++; $display("FAIL sdr_sync got=timeout exp=strobe"); end
    cyc(3);
    in_valid_s = 1'b1; in_data_s = w; exp_s_q.push_back(w);
    cyc(1);
    in_valid_s = 1'b0;
    cyc(5);
    n_checks++; if (strobe_s !== 1'b0 || out_s !== 3'b111) begin n_fail++; $display("FAIL sdr_edge6 got=%b/%b exp=0/111", strobe_s, out_s); end
    cyc(1);
    n_checks++; if (strobe_s !== 1'b1) begin n_fail++; $display("FAIL sdr_edge7_strobe got=%b exp=1", strobe_s); end
    g = '0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < C; c++) g[c*W + b] = out_s[c];
      cyc(1);
    end
    n_checks++; if (g !== exp_s_q.pop_front()) begin n_fail++; $display("FAIL sdr_symbol got=%h exp=%h", g, w); end
  endtask

  task automatic test_reset_mid();
    int t;
    send({10'h155, 10'h000, 10'h3FF});
    in_valid = 1'b0;
    t = 0;
    while (!(strobe && out_bits[1:0] == 2'b11) && t < 40) begin cyc(1); t++; end
    cyc(2);
    n_checks++; if (out_bits !== 6'b010011) begin n_fail++; $display("FAIL pre_reset_bits got=%b exp=010011", out_bits); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (out_bits !== 6'd0 || strobe !== 1'b0) begin n_fail++; $display("FAIL async_reset_out got=%b/%b exp=0/0", out_bits, strobe); end
    n_checks++; if (in_ready !== 1'b1 || uf !== 1'b0 || cnt !== 16'd0) begin n_fail++; $display("FAIL async_reset_ctl got=%b/%b/%0d exp=1/0/0", in_ready, uf, cnt); end
    cyc(2);
    rst = 1'b0;
    exp_q.delete(); got_q.delete(); got_m_q.delete();
    cyc(1);
    n_checks++; if (strobe !== 1'b1 || out_bits !== 6'b000000) begin n_fail++; $display("FAIL post_reset_idle got=%b/%b exp=1/000000", strobe, out_bits); end
    cyc(10);
    n_checks++; if (uf !== 1'b0 || cnt !== 16'd0) begin n_fail++; $display("FAIL post_reset_unarmed got=%b/%0d exp=0/0", uf, cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_bit_order();
    test_underflow();
    test_saturation();
    test_scoreboard();
    test_sdr_latency();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
